snn_readout: RTL and testbench

- Output-stage readout downstream of the hidden neuron layer.
- Counts each class's spikes (one spike line per class) over a fixed window of WINDOW clock cycles (one timestep per cycle).
- Finds the winning class with a sequential argmax.
- Presents the class index and its count to the host through a valid/ready handshake.

---
 rtl/snn_readout.sv | 195 +++++++++++++++++++
 tb/tb_snn_readout.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_readout.sv
// -----------------------------------------------------------------------------
// snn_readout
//
// Output-stage readout for a spiking network. Counts the spikes on each class
// line over a fixed window of WINDOW cycles (one timestep per cycle), then runs
// a sequential argmax over the class counters, one class per cycle. The winning
// class index and its count are presented to the host via valid/ready.
//
// Optional feature macro: SNN_READOUT_TIE_EN
//   When defined, adds output out_tie, which is high (alongside out_valid) when
//   at least one class other than out_class has the same count as out_class.
//
// Parameters:
//   NUM_CLASS  number of class spike lines (>=2)
//   WINDOW     accumulation length in cycles (>=1)
//   CNT_W      per-class counter width; counters saturate at all-ones
//   CLS_W      class index width, $clog2(NUM_CLASS)
//
// Ports:
//   clk        clock, all logic on rising edge
//   reset      synchronous active-high reset
//   start      begin one classification (sampled only in IDLE)
//   spk_in     per-class spike vector, sampled only in ACCUM
//   busy       high in ACCUM and ARGMAX
//   out_valid  result valid (DONE state)
//   out_ready  host accepts result
//   out_class  winning class index
//   out_count  spike count of the winning class
//   out_tie    (SNN_READOUT_TIE_EN only) another class shares the winning count
// -----------------------------------------------------------------------------
module snn_readout #(
  parameter  int NUM_CLASS = 4,
  parameter  int WINDOW    = 16,
  parameter  int CNT_W     = 8,
  localparam int CLS_W     = $clog2(NUM_CLASS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CLASS-1:0] spk_in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CLS_W-1:0]     out_class,
  output logic [CNT_W-1:0]     out_count
`ifdef SNN_READOUT_TIE_EN
  ,
  output logic                 out_tie
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_ARGMAX = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Window counter sized so that WINDOW-1 always fits, including WINDOW=1.
  localparam int               WIN_W    = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASS - 1);

  logic [1:0]       r_state;
  logic [WIN_W-1:0] r_win;
  logic [CLS_W-1:0] r_idx;
  logic [CLS_W-1:0] r_best_idx;
  logic [CNT_W-1:0] r_best_cnt;
  logic [CLS_W-1:0] r_out_class;
  logic [CNT_W-1:0] r_out_count;

  logic [CNT_W-1:0] r_cnt      [NUM_CLASS];
  logic [CNT_W-1:0] w_cnt_next [NUM_CLASS];

  logic             w_clear;
  logic             w_accum;
  logic [CNT_W-1:0] w_cur;
  logic             w_first;
  logic             w_gt;
  logic [CLS_W-1:0] w_best_idx_next;
  logic [CNT_W-1:0] w_best_cnt_next;

  // Counters are cleared on the start edge so a new window never sees
  // leftovers from a previous run or from an aborted one.
  assign w_clear = (r_state == S_IDLE) && start;
  assign w_accum = (r_state == S_ACCUM);

  // Saturating increment per class; holding at all-ones prevents wrap.
  generate
    for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_cnt
      assign w_cnt_next[gi] = (spk_in[gi] && (r_cnt[gi] != {CNT_W{1'b1}}))
                              ? r_cnt[gi] + 1'b1 : r_cnt[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (reset || w_clear) begin
        r_cnt[i] <= '0;
      end else if (w_accum) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  // Argmax step: class 0 seeds the running best; later classes replace it only
  // on a strictly greater count, so ties keep the lowest index.
  assign w_cur           = r_cnt[r_idx];
  assign w_first         = (r_idx == '0);
  assign w_gt            = (w_cur > r_best_cnt);
  assign w_best_idx_next = (w_first || w_gt) ? r_idx : r_best_idx;
  assign w_best_cnt_next = (w_first || w_gt) ? w_cur : r_best_cnt;

`ifdef SNN_READOUT_TIE_EN
  logic r_tie;
  logic r_out_tie;
  logic w_tie_next;

  // An equal compare flags a tie; a new strict maximum invalidates any earlier
  // tie because it was a tie on a smaller count.
  always_comb begin
    w_tie_next = r_tie;
    if (w_first || w_gt) begin
      w_tie_next = 1'b0;
    end else if (w_cur == r_best_cnt) begin
      w_tie_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tie     <= 1'b0;
      r_out_tie <= 1'b0;
    end else if (r_state == S_ARGMAX) begin
      r_tie <= w_tie_next;
      if (r_idx == CLS_LAST) begin
        r_out_tie <= w_tie_next;
      end
    end
  end

  assign out_tie = r_out_tie;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_best_cnt  <= '0;
      r_out_class <= '0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACCUM;
            r_win   <= '0;
          end
        end
        S_ACCUM: begin
          if (r_win == WIN_LAST) begin
            r_state <= S_ARGMAX;
            r_idx   <= '0;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
        S_ARGMAX: begin
          r_best_idx <= w_best_idx_next;
          r_best_cnt <= w_best_cnt_next;
          if (r_idx == CLS_LAST) begin
            r_out_class <= w_best_idx_next;
            r_out_count <= w_best_cnt_next;
            r_idx       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_ACCUM) || (r_state == S_ARGMAX);
  assign out_valid = (r_state == S_DONE);
  assign out_class = r_out_class;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_snn_readout.sv
// -----------------------------------------------------------------------------
// tb_snn_readout
//
// Directed testbench for snn_readout. A default instance (NUM_CLASS=4,
// WINDOW=16, CNT_W=8) covers reset, latency, argmax/tie resolution, handshake
// hold and mid-run reset; a second instance (CNT_W=4, WINDOW=20) covers counter
// saturation. Honours SNN_READOUT_TIE_EN for the out_tie checks.
// -----------------------------------------------------------------------------
module tb_snn_readout;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] spk_in;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_class;
  logic [7:0] out_count;
  logic       tie;

  logic       s_start;
  logic [3:0] s_spk;
  logic       s_busy;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_class;
  logic [3:0] s_count;
  logic       s_tie;

  int total = 0;
  int bad   = 0;

  logic [3:0] pat [16];

  always #5 clk = ~clk;

  snn_readout #(.NUM_CLASS(4), .WINDOW(16), .CNT_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .spk_in    (spk_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count)
`ifdef SNN_READOUT_TIE_EN
    ,
    .out_tie   (tie)
`endif
  );

  snn_readout #(.NUM_CLASS(4), .WINDOW(20), .CNT_W(4)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .start     (s_start),
    .spk_in    (s_spk),
    .busy      (s_busy),
    .out_valid (s_valid),
    .out_ready (s_ready),
    .out_class (s_class),
    .out_count (s_count)
`ifdef SNN_READOUT_TIE_EN
    ,
    .out_tie   (s_tie)
`endif
  );

`ifndef SNN_READOUT_TIE_EN
  assign tie   = 1'b0;
  assign s_tie = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one window with pat[] on the default instance and checks latency and
  // the result. exp_tie is only compared when the tie feature is built in.
  task automatic run_main(input string name, input logic [1:0] exp_cls,
                          input logic [7:0] exp_cnt, input logic exp_tie);
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
    end
    for (int k = 0; k < 16; k++) begin
      spk_in = pat[k];
      tick();
    end
    spk_in = 4'b0000;
    repeat (3) tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s early_valid got valid=%b busy=%b exp valid=0 busy=1",
               name, out_valid, busy);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s valid_latency got valid=%b busy=%b exp valid=1 busy=0",
               name, out_valid, busy);
    end
    total++;
    if (out_class !== exp_cls || out_count !== exp_cnt) begin
      bad++;
      $display("FAIL %s result got class=%0d count=%0d exp class=%0d count=%0d (tie exp %b)",
               name, out_class, out_count, exp_cls, exp_cnt, exp_tie);
    end
`ifdef SNN_READOUT_TIE_EN
    total++;
    if (tie !== exp_tie) begin
      bad++;
      $display("FAIL %s tie got=%b exp=%b", name, tie, exp_tie);
    end
`endif
    $display("run %s: class=%0d count=%0d tie=%b", name, out_class, out_count, tie);
  endtask

  task automatic accept(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s accept got valid=%b busy=%b exp valid=0 busy=0",
               name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; spk_in = '0; out_ready = 1'b0;
    s_start = 1'b0; s_spk = '0; s_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_class !== 2'd0 || out_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state got busy=%b valid=%b class=%0d count=%0d exp 0 0 0 0",
               busy, out_valid, out_class, out_count);
    end
`ifdef SNN_READOUT_TIE_EN
    total++;
    if (tie !== 1'b0) begin
      bad++;
      $display("FAIL reset_tie got=%b exp=0", tie);
    end
`endif
    // Spikes while idle must not start anything or leak into the next run.
    for (int k = 0; k < 6; k++) begin
      spk_in = (k % 2 == 0) ? 4'b1110 : 4'b0110;
      tick();
    end
    spk_in = '0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_spikes got busy=%b valid=%b exp 0 0", busy, out_valid);
    end
    for (int k = 0; k < 16; k++) pat[k] = 4'b0000;
    run_main("all_zero", 2'd0, 8'd0, 1'b1);
    accept("all_zero");
  endtask

  task automatic test_single_class();
    for (int k = 0; k < 16; k++) pat[k] = 4'b0100;
    run_main("class2_full", 2'd2, 8'd16, 1'b0);
    accept("class2_full");
  endtask

  task automatic test_tie();
    // c0=2, c1=5, c2=0, c3=5: tie on 5 resolves to class 1.
    for (int k = 0; k < 16; k++) pat[k] = 4'b0000;
    pat[0] = 4'b1011; pat[1] = 4'b1011;
    pat[2] = 4'b1010; pat[3] = 4'b1010; pat[4] = 4'b1010;
    run_main("tie_1_3", 2'd1, 8'd5, 1'b1);
    accept("tie_1_3");
    // One more spike on class 3 makes it a strict winner.
    pat[5] = 4'b1000;
    run_main("class3_wins", 2'd3, 8'd6, 1'b0);
    accept("class3_wins");
  endtask

  task automatic test_saturate();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_spk = 4'b0001;
    repeat (20) tick();
    s_spk = 4'b0000;
    repeat (3) tick();
    total++;
    if (s_valid !== 1'b0) begin
      bad++;
      $display("FAIL sat_early_valid got=%b exp=0", s_valid);
    end
    tick();
    total++;
    if (s_valid !== 1'b1 || s_class !== 2'd0 || s_count !== 4'd15) begin
      bad++;
      $display("FAIL sat_result got valid=%b class=%0d count=%0d exp valid=1 class=0 count=15",
               s_valid, s_class, s_count);
    end
`ifdef SNN_READOUT_TIE_EN
    total++;
    if (s_tie !== 1'b0) begin
      bad++;
      $display("FAIL sat_tie got=%b exp=0", s_tie);
    end
`endif
    $display("run saturate: class=%0d count=%0d", s_class, s_count);
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    total++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0) begin
      bad++;
      $display("FAIL sat_accept got valid=%b busy=%b exp 0 0", s_valid, s_busy);
    end
  endtask

  task automatic test_hold_handshake();
    for (int k = 0; k < 16; k++) pat[k] = 4'b0100;
    run_main("hold_setup", 2'd2, 8'd16, 1'b0);
    for (int i = 0; i < 10; i++) begin
      start  = (i == 5);
      spk_in = 4'b1111;
      tick();
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || out_class !== 2'd2 || out_count !== 8'd16) begin
        bad++;
        $display("FAIL hold_cycle%0d got valid=%b busy=%b class=%0d count=%0d exp 1 0 2 16",
                 i, out_valid, busy, out_class, out_count);
      end
    end
    start  = 1'b0;
    spk_in = '0;
    accept("hold_release");
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_class !== 2'd2 || out_count !== 8'd16) begin
      bad++;
      $display("FAIL hold_no_queue got busy=%b valid=%b class=%0d count=%0d exp 0 0 2 16",
               busy, out_valid, out_class, out_count);
    end
  endtask

  task automatic test_reset_mid_accum();
    start = 1'b1;
    tick();
    start = 1'b0;
    spk_in = 4'b0111;
    repeat (8) tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_accum_busy got=%b exp=1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    spk_in = '0;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_class !== 2'd0 || out_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset got busy=%b valid=%b class=%0d count=%0d exp 0 0 0 0",
               busy, out_valid, out_class, out_count);
    end
    tick();
    for (int k = 0; k < 16; k++) pat[k] = 4'b1000;
    run_main("after_reset", 2'd3, 8'd16, 1'b0);
    accept("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_class();
    test_tie();
    test_saturate();
    test_hold_handshake();
    test_reset_mid_accum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
